// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes, ALU/immediate codes, datapath mux selects and the per-state
// control word.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // Registered control word; the in_* flags gate the input-dependent enables.
  typedef struct packed {
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_write;
    logic       in_fetch;
    logic       in_decode;
    logic       in_jal;
    logic       in_beq;
  } ctrl_t;

  function automatic logic legal_op(logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_I) ||
           (op == OP_BEQ) || (op == OP_JAL);
  endfunction

  function automatic logic [1:0] imm_sel(logic [6:0] op);
    logic [1:0] s;
    s = IMM_I;
    if (op == OP_SW)  s = IMM_S;
    if (op == OP_BEQ) s = IMM_B;
    if (op == OP_JAL) s = IMM_J;
    return s;
  endfunction

  // Moore control word for a state; unknown encodings look like FETCH with enables off.
  function automatic ctrl_t state_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURES; c.in_fetch = 1'b1; end
      S_DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; c.in_decode = 1'b1; end
      S_MEMADR:   begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; end
      S_MEMREAD:  begin c.adr_src = 1'b1; c.result_src = RES_ALUOUT; end
      S_MEMWB:    begin c.result_src = RES_RDATA; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.result_src = RES_ALUOUT; c.mem_write = 1'b1; end
      S_EXECR:    begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2; c.alu_op = ALUOP_FUNCT; end
      S_EXECI:    begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_FUNCT; end
      S_ALUWB:    begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; end
      S_JAL:      begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.in_jal = 1'b1; end
      S_BEQ:      begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2; c.alu_op = ALUOP_SUB; c.in_beq = 1'b1; end
      default:    begin c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURES; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the instruction register / datapath and the control FSM.
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       reg_write;
  logic       illegal_instr;

  // Datapath side: supplies instruction fields and status, consumes controls.
  modport master (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_control, reg_write, illegal_instr
  );

  // Control unit side.
  modport slave (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_control, reg_write, illegal_instr
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: FSM-level alu_op plus funct fields -> alu_control.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // funct decode only for ALUOP_FUNCT; sub needs op[5] so addi never subtracts.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM. State and the Moore control word are
// registered together; enables that depend on mem_ready/zero/op are gated
// from registered state flags.
module multicycle_control
  import riscv_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.slave   bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   ready;

  assign ready = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.op == OP_LW)      state_d = S_MEMREAD;
        else if (bus.op == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_FETCH;
      end
      S_MEMREAD:  if (ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
    ctrl_d = state_ctrl(state_d);
  end

  // FSM register: state and its control word move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  alu_decoder u_alu_dec (
    .alu_op      (ctrl_q.alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (bus.alu_control)
  );

  assign bus.adr_src       = ctrl_q.adr_src;
  assign bus.result_src    = ctrl_q.result_src;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.imm_src       = imm_sel(bus.op);
  assign bus.ir_write      = ctrl_q.in_fetch & ready;
  assign bus.pc_write      = (ctrl_q.in_fetch & ready) | ctrl_q.in_jal | (ctrl_q.in_beq & bus.zero);
  assign bus.illegal_instr = ctrl_q.in_decode & ~legal_op(bus.op);

endmodule
